// File: rtl/asfifo_wr_packer.sv
// asfifo_wr_packer: write-side feeder for the async FIFO (WClk domain).
// Packs RATIO input lanes into one word {last, lane_count-1, lanes}. It then
// drives the FIFO write port through a one-word hold stage. Writes are
// throttled on fifo_full, so no word is ever dropped.
// Optional feature: define PACKER_TIMEOUT_EN to flush a partial word after
// TIMEOUT idle cycles. The default build has no idle counter.
module asfifo_wr_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   parameter int CNT_W    = 2,
   parameter int FIFO_W   = IN_WIDTH*RATIO+CNT_W+1,
   parameter int TIMEOUT  = 15
) (
   input  logic                PresetFull,
   input  logic                WClk,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [FIFO_W-1:0]   fifo_data,
   output logic                fifo_wen,
   input  logic                fifo_full,
   output logic [15:0]         word_cnt
);

   localparam int DW = IN_WIDTH*RATIO;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [FIFO_W-1:0]   pack_r;        // lanes while filling, full word while stalled
   logic [CNT_W-1:0]    idx_r;
   logic [FIFO_W-1:0]   hold_r;
   logic                hold_valid_r;
   logic [15:0]         word_cnt_r;

   logic                accept_s;
   logic                pop_s;
   logic                timeout_s;
   logic                complete_s;
   logic                load_hold_s;
   logic [DW-1:0]       lanes_merged_s;
   logic [FIFO_W-1:0]   word_s;
   logic [FIFO_W-1:0]   hold_src_s;

   assign accept_s  = in_valid & in_ready;
   // fifo_wen must track fifo_full combinationally, so a write is never issued while full.
   assign pop_s     = hold_valid_r & ~fifo_full;
   assign fifo_wen  = pop_s;
   // hold_r is zeroed whenever it empties, so it can drive fifo_data directly.
   assign fifo_data = hold_r;
   assign word_cnt  = word_cnt_r;

`ifdef PACKER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT+1);

   logic [TO_W-1:0] idle_cnt_r;

   assign timeout_s = (state_r == FILL) && (idx_r != {CNT_W{1'b0}}) && !accept_s &&
                      (idle_cnt_r == TO_W'(TIMEOUT-1));

   // Idle counter: counts FILL cycles with a partial word and no accepted lane.
   always_ff @(posedge WClk or posedge PresetFull) begin
      if (PresetFull) begin
         idle_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r == FILL) && (idx_r != {CNT_W{1'b0}}) && !accept_s && !timeout_s) begin
         idle_cnt_r <= idle_cnt_r + TO_W'(1);
      end else begin
         idle_cnt_r <= {TO_W{1'b0}};
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Lane merge: insert the incoming lane at position idx into the pack lanes.
   always_comb begin
      lanes_merged_s = pack_r[DW-1:0];
      for (int i = 0; i < RATIO; i++) begin
         if (idx_r == CNT_W'(i)) begin
            lanes_merged_s[i*IN_WIDTH +: IN_WIDTH] = in_data;
         end else begin
            lanes_merged_s[i*IN_WIDTH +: IN_WIDTH] = pack_r[i*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   // Completion detect: a full word, a frame end, or an idle flush of a partial word.
   always_comb begin
      complete_s = 1'b0;
      word_s     = {FIFO_W{1'b0}};
      if ((state_r == FILL) && accept_s) begin
         if ((idx_r == CNT_W'(RATIO-1)) || in_last) begin
            complete_s = 1'b1;
            word_s     = {in_last, idx_r, lanes_merged_s};
         end else begin
            complete_s = 1'b0;
         end
      end else if (timeout_s) begin
         // Tag is lanes filled minus one; the filled count equals idx here.
         complete_s = 1'b1;
         word_s     = {1'b0, idx_r - CNT_W'(1), pack_r[DW-1:0]};
      end else begin
         complete_s = 1'b0;
      end
   end

   // Hold load decision: a new word enters hold when hold is free or drains this cycle.
   always_comb begin
      load_hold_s = 1'b0;
      hold_src_s  = word_s;
      case (state_r)
         FILL: begin
            load_hold_s = complete_s && (!hold_valid_r || pop_s);
            hold_src_s  = word_s;
         end
         STALL: begin
            load_hold_s = pop_s;
            hold_src_s  = pack_r;
         end
         default: begin
            load_hold_s = 1'b0;
            hold_src_s  = word_s;
         end
      endcase
   end

   // State register.
   always_ff @(posedge WClk or posedge PresetFull) begin
      if (PresetFull) begin
         state_r <= FILL;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: stall when a completed word finds hold occupied and not draining.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FILL: begin
            if (complete_s && hold_valid_r && !pop_s) begin
               state_nxt_s = STALL;
            end else begin
               state_nxt_s = FILL;
            end
         end
         STALL: begin
            if (pop_s) begin
               state_nxt_s = FILL;
            end else begin
               state_nxt_s = STALL;
            end
         end
         default: state_nxt_s = FILL;
      endcase
   end

   // Outputs: lanes are accepted only while filling.
   always_comb begin
      in_ready = 1'b1;
      case (state_r)
         FILL:    in_ready = 1'b1;
         STALL:   in_ready = 1'b0;
         default: in_ready = 1'b1;
      endcase
   end

   // Pack register and lane index.
   always_ff @(posedge WClk or posedge PresetFull) begin
      if (PresetFull) begin
         pack_r <= {FIFO_W{1'b0}};
         idx_r  <= {CNT_W{1'b0}};
      end else if (state_r == STALL) begin
         if (pop_s) begin
            pack_r <= {FIFO_W{1'b0}};
         end else begin
            pack_r <= pack_r;
         end
         idx_r <= {CNT_W{1'b0}};
      end else if (complete_s) begin
         idx_r <= {CNT_W{1'b0}};
         if (load_hold_s) begin
            pack_r <= {FIFO_W{1'b0}};
         end else begin
            pack_r <= word_s;      // park the finished word until hold drains
         end
      end else if (accept_s) begin
         pack_r <= {{(CNT_W+1){1'b0}}, lanes_merged_s};
         idx_r  <= idx_r + CNT_W'(1);
      end else begin
         pack_r <= pack_r;
         idx_r  <= idx_r;
      end
   end

   // Hold stage: the word presented to the FIFO, zeroed when it empties.
   always_ff @(posedge WClk or posedge PresetFull) begin
      if (PresetFull) begin
         hold_r       <= {FIFO_W{1'b0}};
         hold_valid_r <= 1'b0;
      end else if (load_hold_s) begin
         hold_r       <= hold_src_s;
         hold_valid_r <= 1'b1;
      end else if (pop_s) begin
         hold_r       <= {FIFO_W{1'b0}};
         hold_valid_r <= 1'b0;
      end else begin
         hold_r       <= hold_r;
         hold_valid_r <= hold_valid_r;
      end
   end

   // Written-word counter, wrapping at 16 bits.
   always_ff @(posedge WClk or posedge PresetFull) begin
      if (PresetFull) begin
         word_cnt_r <= 16'd0;
      end else if (pop_s) begin
         word_cnt_r <= word_cnt_r + 16'd1;
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

endmodule

// File: tb/tb_asfifo_wr_packer.sv
// Directed self-checking bench for asfifo_wr_packer (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_asfifo_wr_packer;

   localparam int FW = 35;

   logic          PresetFull;
   logic          WClk;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [FW-1:0] fifo_data;
   logic          fifo_wen;
   logic          fifo_full;
   logic [15:0]   word_cnt;

   logic full_force;
   logic toggle_en;
   logic toggle_r;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int stall_cnt = 0;
   int cyc       = 0;

   logic [FW-1:0] got_q[$];
   int            cyc_q[$];

   asfifo_wr_packer dut (
      .PresetFull (PresetFull),
      .WClk       (WClk),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .fifo_data  (fifo_data),
      .fifo_wen   (fifo_wen),
      .fifo_full  (fifo_full),
      .word_cnt   (word_cnt)
   );

   assign fifo_full = full_force | (toggle_en & toggle_r);

   initial WClk = 1'b0;
   always #5 WClk = ~WClk;

   always @(negedge WClk) toggle_r <= ~toggle_r;

   // FIFO model: records every word written and the cycle it was written.
   always @(posedge WClk) begin
      cyc <= cyc + 1;
      if (fifo_wen === 1'b1) begin
         got_q.push_back(fifo_data);
         cyc_q.push_back(cyc);
      end
   end

   function automatic logic [FW-1:0] mk(input logic last, input logic [1:0] tag,
                                        input logic [31:0] lanes);
      return {last, tag, lanes};
   endfunction

   function automatic logic [FW-1:0] q_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return {FW{1'bx}};
   endfunction

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      check_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   // Called on a falling edge; returns on the falling edge after the lane is taken.
   task automatic send_lane(input logic [7:0] d, input logic l);
      int guard;
      guard = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      while (in_ready !== 1'b1 && guard < 200) begin
         @(negedge WClk);
         guard++;
         stall_cnt++;
      end
      if (guard >= 200) begin
         check_cnt++;
         $display("FAIL send_lane_timeout: in_ready=%b expected 1 within 200 cycles", in_ready);
      end
      @(negedge WClk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_reset();
      PresetFull = 1'b1;
      @(negedge WClk);
      PresetFull = 1'b0;
      got_q.delete();
      cyc_q.delete();
   endtask

   task automatic test_reset();
      PresetFull = 1'b1;
      repeat (2) @(negedge WClk);
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
      check_cnt++; if (fifo_wen !== 1'b0) $display("FAIL rst_fifo_wen: got %b expected 0", fifo_wen); else pass_cnt++;
      check_cnt++; if (fifo_data !== 35'h0) $display("FAIL rst_fifo_data: got %h expected 0", fifo_data); else pass_cnt++;
      check_cnt++; if (word_cnt !== 16'd0) $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); else pass_cnt++;
      PresetFull = 1'b0;
      got_q.delete();
      cyc_q.delete();
      @(negedge WClk);
   endtask

   task automatic test_stream8();
      stall_cnt = 0;
      for (int i = 1; i <= 8; i++) send_lane(8'(i), (i == 8));
      repeat (3) @(negedge WClk);
      check_cnt++; if (got_q.size() !== 2) $display("FAIL s8_count: got %0d expected 2", got_q.size()); else pass_cnt++;
      chk("s8_word0", q_at(0), mk(1'b0, 2'd3, 32'h04030201));
      chk("s8_word1", q_at(1), mk(1'b1, 2'd3, 32'h08070605));
      check_cnt++; if (word_cnt !== 16'd2) $display("FAIL s8_word_cnt: got %0d expected 2", word_cnt); else pass_cnt++;
      check_cnt++; if (stall_cnt !== 0) $display("FAIL s8_in_ready: got %0d stalls expected 0", stall_cnt); else pass_cnt++;
   endtask

   task automatic test_frame3();
      send_lane(8'hAA, 1'b0);
      send_lane(8'hBB, 1'b0);
      send_lane(8'hCC, 1'b1);
      // Cycle right after the completing lane: the write must be on the port now.
      check_cnt++; if (fifo_wen !== 1'b1) $display("FAIL f3_latency_wen: got %b expected 1", fifo_wen); else pass_cnt++;
      chk("f3_data", fifo_data, mk(1'b1, 2'd2, 32'h00CCBBAA));
      @(negedge WClk);
      check_cnt++; if (word_cnt !== 16'd3) $display("FAIL f3_word_cnt: got %0d expected 3", word_cnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      got_q.delete();
      cyc_q.delete();
      full_force = 1'b1;
      for (int i = 0; i < 8; i++) send_lane(8'h11 + 8'(i), 1'b0);
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL bb_in_ready_low: got %b expected 0", in_ready); else pass_cnt++;
      check_cnt++; if (fifo_wen !== 1'b0) $display("FAIL bb_wen_while_full: got %b expected 0", fifo_wen); else pass_cnt++;
      check_cnt++; if (got_q.size() !== 0) $display("FAIL bb_no_write_full: got %0d expected 0", got_q.size()); else pass_cnt++;
      full_force = 1'b0;
      for (int i = 8; i < 12; i++) send_lane(8'h11 + 8'(i), (i == 11));
      repeat (3) @(negedge WClk);
      check_cnt++; if (got_q.size() !== 3) $display("FAIL bb_count: got %0d expected 3", got_q.size()); else pass_cnt++;
      chk("bb_word0", q_at(0), mk(1'b0, 2'd3, 32'h14131211));
      chk("bb_word1", q_at(1), mk(1'b0, 2'd3, 32'h18171615));
      chk("bb_word2", q_at(2), mk(1'b1, 2'd3, 32'h1C1B1A19));
      check_cnt++;
      if (cyc_q.size() < 2 || cyc_q[1] - cyc_q[0] != 1)
         $display("FAIL bb_back_to_back: got gap %0d expected 1", (cyc_q.size() < 2) ? -1 : cyc_q[1] - cyc_q[0]);
      else pass_cnt++;
      check_cnt++; if (word_cnt !== 16'd6) $display("FAIL bb_word_cnt: got %0d expected 6", word_cnt); else pass_cnt++;
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL bb_in_ready_back: got %b expected 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      send_lane(8'h31, 1'b0);
      send_lane(8'h32, 1'b0);
      PresetFull = 1'b1;
      @(negedge WClk);
      check_cnt++; if (word_cnt !== 16'd0) $display("FAIL rm_word_cnt_clr: got %0d expected 0", word_cnt); else pass_cnt++;
      check_cnt++; if (fifo_wen !== 1'b0) $display("FAIL rm_wen: got %b expected 0", fifo_wen); else pass_cnt++;
      PresetFull = 1'b0;
      got_q.delete();
      cyc_q.delete();
      for (int i = 0; i < 4; i++) send_lane(8'h21 + 8'(i), (i == 3));
      repeat (3) @(negedge WClk);
      check_cnt++; if (got_q.size() !== 1) $display("FAIL rm_count: got %0d expected 1", got_q.size()); else pass_cnt++;
      chk("rm_word0", q_at(0), mk(1'b1, 2'd3, 32'h24232221));
      check_cnt++; if (word_cnt !== 16'd1) $display("FAIL rm_word_cnt: got %0d expected 1", word_cnt); else pass_cnt++;
   endtask

   task automatic test_toggle_full();
      int guard;
      logic [31:0] lanes;
      pulse_reset();
      toggle_en = 1'b1;
      for (int i = 0; i < 64; i++) send_lane(8'(i), (i == 63));
      guard = 0;
      while (got_q.size() < 16 && guard < 40) begin
         @(negedge WClk);
         guard++;
      end
      toggle_en = 1'b0;
      repeat (2) @(negedge WClk);
      check_cnt++; if (got_q.size() !== 16) $display("FAIL tg_count: got %0d expected 16", got_q.size()); else pass_cnt++;
      for (int w = 0; w < 16; w++) begin
         lanes = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         chk($sformatf("tg_word%0d", w), q_at(w), mk((w == 15), 2'd3, lanes));
      end
      check_cnt++; if (word_cnt !== 16'd16) $display("FAIL tg_word_cnt: got %0d expected 16", word_cnt); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int k;
      pulse_reset();
      send_lane(8'h5A, 1'b0);
      k = 0;
      while (fifo_wen !== 1'b1 && k < 40) begin
         @(negedge WClk);
         k++;
      end
`ifdef PACKER_TIMEOUT_EN
      check_cnt++; if (k != 15) $display("FAIL to_delay: got %0d idle cycles expected 15", k); else pass_cnt++;
      chk("to_word", fifo_data, mk(1'b0, 2'd0, 32'h0000005A));
`else
      check_cnt++; if (k != 40) $display("FAIL to_no_flush: got write after %0d cycles expected none", k); else pass_cnt++;
      check_cnt++; if (got_q.size() !== 0) $display("FAIL to_no_write: got %0d expected 0", got_q.size()); else pass_cnt++;
`endif
   endtask

   initial begin
      PresetFull = 1'b1;
      in_data    = 8'h00;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      full_force = 1'b0;
      toggle_en  = 1'b0;
      toggle_r   = 1'b0;
      @(negedge WClk);
      test_reset();
      test_stream8();
      test_frame3();
      test_back_to_back();
      test_reset_midframe();
      test_toggle_full();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/asfifo_wr_packer.md
Name: asfifo_wr_packer

Overview:
Write-side feeder for the async FIFO. It accepts a narrow byte stream with valid/ready/last framing in the WClk domain, packs RATIO lanes into one wide word tagged with lane count and end-of-frame, and drives the FIFO write port. Writes are throttled on the FIFO full flag, so no word is ever dropped. It sits between a WClk-domain producer and the FIFO write port (Data_in/WriteEn_in/Full_out).

Parameters:
IN_WIDTH, 8, width of one input lane.
RATIO, 4, lanes per packed word; power of two, at least 2.
CNT_W, 2, log2(RATIO); width of the lane-count tag.
FIFO_W, IN_WIDTH*RATIO+CNT_W+1, width of fifo_data; set the FIFO DATA_WIDTH to this.
TIMEOUT, 15, idle cycles before a partial-word flush; used only with the optional feature.

Ports:
PresetFull  in  1  reset, asynchronous, active-high
WClk  in  1  clock
in_data  in  IN_WIDTH  input lane
in_valid  in  1  producer has a lane
in_last  in  1  lane is the last of its frame
in_ready  out  1  packer accepts a lane this cycle
fifo_data  out  FIFO_W  to FIFO Data_in
fifo_wen  out  1  to FIFO WriteEn_in
fifo_full  in  1  from FIFO Full_out
word_cnt  out  16  count of words written to the FIFO; wraps

Behaviour:
- Reset: PresetFull is asynchronous and active-high; the block is clocked on WClk. While asserted: lane index=0, pack register and hold register cleared, hold_valid=0, state=FILL, word_cnt=0. Outputs: in_ready=1, fifo_wen=0, fifo_data=0. Asserting reset mid-frame discards the partial word and any held word; nothing is written afterwards.
- Accept: a lane is taken when in_valid and in_ready are both high at a WClk edge. The lane goes to lane position idx (bits idx*IN_WIDTH upward), then idx increments.
- Word format: bits [IN_WIDTH*RATIO-1:0] hold the lanes, with lane 0 in the LSBs and unfilled lanes at 0. The next CNT_W bits hold (lanes filled - 1). The MSB holds the last flag.
- Completion: a word completes when the accepted lane has idx=RATIO-1, or when in_last=1, whichever comes first. On completion idx returns to 0 and the pack register clears.
- Hold register: a one-word output stage. fifo_wen = hold_valid & ~fifo_full, combinational. fifo_data = hold register; it is 0 when hold_valid=0. A pop happens on any cycle where fifo_wen=1, and word_cnt increments on that edge.
- State FILL: in_ready=1.
  - If a word completes and (hold_valid=0 or a pop happens this cycle), the word moves to hold at that edge and the state stays FILL.
  - If a word completes otherwise, the state goes to STALL and the word stays in the pack register.
- State STALL: in_ready=0. On a pop, the pack word moves to hold, the pack register clears, and the state returns to FILL.
- Latency: the completing lane is accepted at edge N, fifo_wen is high during cycle N+1 if fifo_full=0, and the word is in the FIFO at edge N+1.
- Throughput: one lane per cycle is sustained while the FIFO is not full. At most 2 words are buffered (hold plus a stalled pack).
- fifo_full: may assert asynchronously. fifo_wen follows it combinationally, and the hold register keeps its word until a cycle with fifo_full=0.
- Simultaneous cases:
  - A pop and a completion in the same cycle in FILL: the new word replaces the popped one; hold_valid stays 1.
  - in_last on lane RATIO-1: count tag = RATIO-1 and last=1, as a single word.
- in_valid with in_ready=0: the lane is not taken; the producer holds it.

Optional Feature:
PACKER_TIMEOUT_EN
- With the macro defined: an idle counter tracks FILL cycles with idx>0 and no accepted lane. When it reaches TIMEOUT, the partial word completes with last=0 and the same transfer rules apply. The counter clears on any accept, on completion, and on reset.
- Without the macro: a partial word waits indefinitely for more lanes or in_last. The counter logic is absent.

Test Plan:
- Reset then stream 8 lanes 0x01..0x08 with last on 0x08, fifo_full=0: two writes, 0x04030201 with tag 3/last 0, then 0x08070605 with tag 3/last 1. word_cnt=2 and in_ready stays 1.
- Frame of 3 lanes 0xAA,0xBB,0xCC with last: one write, lanes 0x00CCBBAA, tag 2, last 1, on the cycle after 0xCC is accepted.
- Hold fifo_full=1 and stream 12 lanes: fifo_wen=0 throughout. in_ready drops after lane 8, when hold and pack are both full. Release fifo_full: 2 writes back-to-back, in_ready returns high, and the remaining lanes produce a third word. No loss and no duplicates.
- Assert PresetFull mid-frame after 2 lanes, then send a new 4-lane frame: only the new frame's word is written, and word_cnt restarts from 0.
- Toggle fifo_full every cycle during a 64-lane stream: 16 words, in order, all with correct tags; word_cnt=16.
- With PACKER_TIMEOUT_EN and TIMEOUT=15: send 1 lane 0x5A, then idle. A write of 0x0000005A with tag 0, last 0 occurs after 15 idle cycles. Without the macro, no write occurs.
